local_packet_receiver: RTL

//  Destination-side endpoint for packets emitted on packet_out by the ring of local controllers.

---
 rtl/noc_pkt_pkg.sv | 34 +++
 rtl/rx_sync_fifo.sv | 87 ++++++++
 rtl/local_packet_receiver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/noc_pkt_pkg.sv
// ============================================================================
// noc_pkt_pkg : packet header codes and field layout shared by ring endpoints
// Rev 1.0
// ============================================================================
`default_nettype none

package noc_pkt_pkg;

  typedef enum logic [1:0] {
    HDR_IDLE     = 2'b00,
    HDR_DATA     = 2'b01,
    HDR_PREFETCH = 2'b10,
    HDR_LAST     = 2'b11
  } hdr_e;

  localparam int HDR_W    = 2;
  localparam int DATA_LSB = 0;

  // Layout, MSB first: {hdr, dest, data}
  function automatic int dest_lsb(input int dw);
    return 2 * dw;
  endfunction

  function automatic int hdr_lsb(input int dw, input int avw);
    return 2 * dw + avw;
  endfunction

  function automatic int calc_packet_width(input int dw, input int avw);
    return HDR_W + 2 * dw + avw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_sync_fifo.sv
// ============================================================================
// rx_sync_fifo : synchronous FIFO with registered head output and flush
// Rev 1.0
// ============================================================================
`default_nettype none

module rx_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             do_push, do_pop;

  assign o_full   = (count_q == (AW+1)'(DEPTH));
  assign o_empty  = (count_q == '0);
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;

  // Full is judged on the registered count, so a pop never frees a slot early
  assign do_push = i_push & ~o_full & ~i_flush;
  assign do_pop  = i_pop & ~o_empty & ~i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rvalid_d = (count_d != '0);
    rdata_d  = rdata_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rvalid_d = 1'b0;
      rdata_d  = '0;
    end else if (count_d != '0) begin
      // Head is the word being written when the FIFO was otherwise drained
      if (do_push && (wr_ptr_q == rd_ptr_d)) begin
        rdata_d = i_wdata;
      end else begin
        rdata_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/local_packet_receiver.sv
// ============================================================================
// local_packet_receiver : ring destination endpoint; header decode, buffering,
//                         multicast forwarding and frame accounting
// Rev 1.0
// ============================================================================
`default_nettype none

module local_packet_receiver
  import noc_pkt_pkg::*;
#(
  parameter int datawidth            = 16,
  parameter int address_vector_width = 4,
  parameter int NODE_ID              = 0,
  parameter int N_sample             = 256,
  parameter int FIFO_DEPTH           = 8,
  localparam int packet_width        = calc_packet_width(datawidth, address_vector_width)
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [packet_width-1:0]     packet_in,
  output logic                        in_ready,
  input  logic                        scenario_update,
  output logic [2*datawidth-1:0]      out_data,
  output logic                        out_prefetch,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [packet_width-1:0]     packet_fwd,
  output logic [$clog2(N_sample):0]   sample_count,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int DW  = 2 * datawidth;
  localparam int AVW = address_vector_width;
  localparam int CW  = $clog2(N_sample) + 1;

  hdr_e                    hdr;
  logic [AVW-1:0]          dest;
  logic [DW-1:0]           data;
  logic [AVW-1:0]          own_mask;
  logic [AVW-1:0]          fwd_dest;
  logic                    match, accept, drop;
  logic                    fifo_full, fifo_empty;
  logic [DW:0]             fifo_rdata;
  logic [CW-1:0]           count_inc;

  logic [packet_width-1:0] packet_fwd_q, packet_fwd_d;
  logic [CW-1:0]           sample_count_q, sample_count_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overflow_q, overflow_d;

  assign hdr      = hdr_e'(packet_in[hdr_lsb(datawidth, AVW) +: HDR_W]);
  assign dest     = packet_in[dest_lsb(datawidth) +: AVW];
  assign data     = packet_in[DATA_LSB +: DW];
  assign own_mask = AVW'(1) << NODE_ID;
  assign fwd_dest = dest & ~own_mask;

  assign match  = (hdr != HDR_IDLE) & dest[NODE_ID];
  assign accept = match & ~fifo_full & ~scenario_update;
  assign drop   = match & fifo_full & ~scenario_update;

  rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk      (CLK),
    .rst      (reset),
    .i_flush  (scenario_update),
    .i_push   (accept),
    .i_wdata  ({hdr == HDR_PREFETCH, data}),
    .i_pop    (out_valid & out_ready & ~fifo_empty),
    .o_rdata  (fifo_rdata),
    .o_rvalid (out_valid),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty)
  );

  assign in_ready     = ~fifo_full;
  assign out_prefetch = fifo_rdata[DW];
  assign out_data     = fifo_rdata[DW-1:0];
  assign count_inc    = sample_count_q + CW'(1);

  always_comb begin
    packet_fwd_d   = '0;
    sample_count_d = sample_count_q;
    frame_done_d   = 1'b0;
    overflow_d     = overflow_q;
    if (scenario_update) begin
      sample_count_d = '0;
      overflow_d     = 1'b0;
    end else begin
      if ((hdr != HDR_IDLE) && (fwd_dest != '0)) begin
        packet_fwd_d = {hdr, fwd_dest, data};
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
      if (accept) begin
        if ((hdr == HDR_LAST) || (count_inc == CW'(N_sample))) begin
          frame_done_d   = 1'b1;
          sample_count_d = '0;
        end else begin
          sample_count_d = count_inc;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      packet_fwd_q   <= '0;
      sample_count_q <= '0;
      frame_done_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      packet_fwd_q   <= packet_fwd_d;
      sample_count_q <= sample_count_d;
      frame_done_q   <= frame_done_d;
      overflow_q     <= overflow_d;
    end
  end

  assign packet_fwd   = packet_fwd_q;
  assign sample_count = sample_count_q;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;

endmodule

`default_nettype wire
